// File: rtl/work_scheduler_if.sv
// Bundle between the work scheduler and its neighbours: comm work in,
// hasher drive and hit back, golden-nonce handshake and status out.
// master = scheduler side, slave = the jtag_comm/hasher environment.
interface work_scheduler_if;
  logic [255:0] comm_midstate;
  logic [95:0]  comm_data;
  logic [255:0] midstate;
  logic [95:0]  data;
  logic [31:0]  nonce;
  logic         hit;
  logic         golden_valid;
  logic [31:0]  golden_nonce;
  logic         golden_ready;
  logic         busy;
  logic         overflow;

  modport master (
    input  comm_midstate, comm_data, hit, golden_ready,
    output midstate, data, nonce, golden_valid, golden_nonce, busy, overflow
  );

  modport slave (
    output comm_midstate, comm_data, hit, golden_ready,
    input  midstate, data, nonce, golden_valid, golden_nonce, busy, overflow
  );
endinterface

// File: rtl/work_scheduler.sv
// work_scheduler: latches new work from comm, counts nonces into the hasher,
// blanks stale hasher results and queues golden nonces in a small FIFO.
// Optional macro WORK_SCHED_EXHAUST_STOP_EN: stop after one pass over the
// nonce range (RUN -> DRAIN -> EXHAUSTED); otherwise the nonce wraps forever.
module work_scheduler #(
  parameter int PIPE_LATENCY = 254,
  parameter int NONCE_BITS   = 32,
  parameter int FIFO_DEPTH   = 4
) (
  input logic             hash_clk,
  input logic             reset,
  work_scheduler_if.master bus
);
  localparam int BW = $clog2(PIPE_LATENCY + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [32:0]   RANGE      = 33'd1 << NONCE_BITS;
  localparam logic [31:0]   NONCE_MAX  = 32'(RANGE - 33'd1);
  localparam logic [BW-1:0] BLANK_INIT = BW'(PIPE_LATENCY);

`ifdef WORK_SCHED_EXHAUST_STOP_EN
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, EXHAUSTED} state_t;
`else
  typedef enum logic [0:0] {IDLE, RUN} state_t;
`endif

  state_t        state, state_nx;
  logic [31:0]   nonce_nx;
  logic [BW-1:0] blank, blank_nx;
  logic [31:0]   res, res_nx;
  logic          new_work, active, expired, accept;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          full, pop, push_ok;

  // Work-change detect, hit eligibility and next-state/datapath selection.
  // Hit eligibility uses the pre-load state, so a hit coinciding with new
  // work still belongs to the old work.
  always_comb begin
    state_nx = state;
    nonce_nx = bus.nonce;
    blank_nx = blank;
    res_nx   = res;
    new_work = {bus.comm_midstate, bus.comm_data} != {bus.midstate, bus.data};
`ifdef WORK_SCHED_EXHAUST_STOP_EN
    active   = (state == RUN) || (state == DRAIN);
`else
    active   = (state == RUN);
`endif
    expired  = (blank == '0);
    accept   = bus.hit && active && expired;
    if (active && !expired) blank_nx = blank - BW'(1);
    // Result nonce tracks the nonce whose result is on hit this cycle.
    if (active && expired) res_nx = (res + 32'd1) & NONCE_MAX;
    case (state)
      RUN: begin
        nonce_nx = (bus.nonce + 32'd1) & NONCE_MAX;
`ifdef WORK_SCHED_EXHAUST_STOP_EN
        if (nonce_nx == NONCE_MAX) state_nx = DRAIN;
`endif
      end
`ifdef WORK_SCHED_EXHAUST_STOP_EN
      DRAIN: if (expired && res == NONCE_MAX) state_nx = EXHAUSTED;
`endif
      default: ;
    endcase
    if (new_work) begin
      state_nx = RUN;
      nonce_nx = '0;
      blank_nx = BLANK_INIT;
      res_nx   = '0;
    end
  end

  // Scheduler state and held work registers.
  always_ff @(posedge hash_clk) begin
    if (reset) begin
      state        <= IDLE;
      bus.midstate <= '0;
      bus.data     <= '0;
      bus.nonce    <= '0;
      blank        <= '0;
      res          <= '0;
    end else begin
      state     <= state_nx;
      bus.nonce <= nonce_nx;
      blank     <= blank_nx;
      res       <= res_nx;
      if (new_work) begin
        bus.midstate <= bus.comm_midstate;
        bus.data     <= bus.comm_data;
      end
    end
  end

  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop     = (count != '0) && bus.golden_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still takes it.
  assign push_ok = accept && (!full || pop);

  // Golden-nonce FIFO and sticky overflow flag.
  always_ff @(posedge hash_clk) begin
    if (reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      bus.overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= res;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (accept && !push_ok) bus.overflow <= 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  assign bus.golden_valid = (count != '0);
  assign bus.golden_nonce = (count != '0) ? mem[rd_ptr] : '0;
`ifdef WORK_SCHED_EXHAUST_STOP_EN
  assign bus.busy = (state == RUN) || (state == DRAIN);
`else
  assign bus.busy = (state == RUN);
`endif
endmodule

// File: tb/tb_work_scheduler.sv
// Randomized bench for work_scheduler. The reference model describes the
// block by cycle arithmetic relative to the last load cycle and keeps the
// golden FIFO as a queue.
module tb_work_scheduler;
  localparam int PL   = 4;
  localparam int NB   = 8;
  localparam int DEP  = 4;
  localparam int MAXN = (1 << NB) - 1;

  logic hash_clk = 1'b0;
  logic reset;
  work_scheduler_if bus();

  work_scheduler #(.PIPE_LATENCY(PL), .NONCE_BITS(NB), .FIFO_DEPTH(DEP)) dut (
    .hash_clk (hash_clk),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 hash_clk = ~hash_clk;

  int n_cmp = 0;
  int n_err = 0;

  // model state
  int           t;
  bit           loaded;
  int           lc;
  logic [255:0] hms;
  logic [95:0]  hdata;
  int           q[$];
  bit           ovf;
  bit           fresh;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int exp_nonce();
    int k;
    if (!loaded) return 0;
    k = t - lc - 1;
`ifdef WORK_SCHED_EXHAUST_STOP_EN
    return (k > MAXN) ? MAXN : k;
`else
    return k % (MAXN + 1);
`endif
  endfunction

  function automatic bit exp_busy();
    if (!loaded) return 1'b0;
`ifdef WORK_SCHED_EXHAUST_STOP_EN
    return (t - lc - 1) <= PL + MAXN;
`else
    return 1'b1;
`endif
  endfunction

  // nonce index whose result is on hit in cycle t, or -1 if not eligible
  function automatic int hit_index();
    int j;
    if (!loaded) return -1;
    j = t - lc - 1 - PL;
    if (j < 0) return -1;
`ifdef WORK_SCHED_EXHAUST_STOP_EN
    if (j > MAXN) return -1;
`endif
    return j % (MAXN + 1);
  endfunction

  // one cycle: check outputs, drive inputs, advance the model over the edge
  task automatic cycle(input bit rst, input bit chg, input bit h, input bit rdy);
    int  j, pre;
    bit  pp;
    @(negedge hash_clk);
    chk("nonce",    256'(bus.nonce), 256'(exp_nonce()));
    chk("midstate", bus.midstate, hms);
    chk("data",     256'(bus.data), 256'(hdata));
    chk("busy",     256'(bus.busy), 256'(exp_busy()));
    chk("overflow", 256'(bus.overflow), 256'(ovf));
    chk("gvalid",   256'(bus.golden_valid), 256'(q.size() != 0));
    if (q.size() != 0)  chk("gnonce", 256'(bus.golden_nonce), 256'(q[0]));
    else if (fresh)     chk("gnonce_rst", 256'(bus.golden_nonce), 256'(0));

    reset            = rst;
    bus.hit          = h;
    bus.golden_ready = rdy;
    if (chg) begin
      bus.comm_midstate = rand256();
      bus.comm_data     = 96'(rand256());
    end

    if (rst) begin
      loaded = 0; hms = '0; hdata = '0; q.delete(); ovf = 0; fresh = 1;
    end else begin
      j   = hit_index();
      pre = q.size();
      pp  = (pre != 0) && rdy;
      if (pp) void'(q.pop_front());
      if (h && j >= 0) begin
        if (pre == DEP && !pp) ovf = 1;
        else begin q.push_back(j); fresh = 0; end
      end
      if ({bus.comm_midstate, bus.comm_data} != {hms, hdata}) begin
        hms = bus.comm_midstate; hdata = bus.comm_data;
        loaded = 1; lc = t;
      end
    end
    t++;
  endtask

  function automatic bit pr(input int n);
    return ($urandom_range(n - 1) == 0);
  endfunction

  initial begin
    reset = 1'b1;
    bus.comm_midstate = '0;
    bus.comm_data     = '0;
    bus.hit           = 1'b0;
    bus.golden_ready  = 1'b0;
    @(posedge hash_clk);
    t = 0; loaded = 0; lc = 0; hms = '0; hdata = '0; ovf = 0; fresh = 1;
    cycle(1, 0, 0, 0);
    // idle: comm zero, hits must be ignored
    for (int i = 0; i < 20; i++) cycle(0, 0, pr(2), pr(2));
    // load, blanking, FIFO fill and overflow with ready low
    cycle(0, 1, 1, 0);
    for (int i = 0; i < 40; i++) cycle(0, pr(25), pr(2), 0);
    // drain in order, overflow must stay sticky; frequent work changes
    for (int i = 0; i < 80; i++) cycle(0, pr(12), pr(2), pr(2));
    // long run: wrap or exhaust, plus post-exhaust hits
    cycle(0, 1, 0, 1);
    for (int i = 0; i < 600; i++) cycle(0, 0, pr(6), pr(4) ? 1'b0 : 1'b1);
    // new work restarts from 0, then a mid-run reset
    cycle(0, 1, 1, 1);
    for (int i = 0; i < 30; i++) cycle(0, 0, pr(2), pr(3));
    cycle(1, 0, 1, 1);
    for (int i = 0; i < 60; i++) cycle(0, pr(15), pr(2), pr(2));
    cycle(0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
